// File: rtl/core_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32I core.
// Walks FETCH/DECODE/EXEC/MEM/WB, runs memory handshakes, traps on faults.
module core_ctrl_fsm #(
    parameter int TIMEOUT_W   = 8,
    parameter int TIMEOUT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        branch_taken,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_we,
    output logic        alu_src_imm,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        halted,
    output logic [1:0]  trap_cause,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_NONE, C_LUI, C_AUIPC, C_JAL, C_JALR,
        C_BRANCH, C_LOAD, C_STORE, C_OPIMM, C_OP
    } cls_t;

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = TIMEOUT_W'(TIMEOUT_MAX);

    state_t               state;
    cls_t                 cls;
    cls_t                 dec_cls;
    logic [TIMEOUT_W-1:0] cnt;
    logic                 taken;

    always_comb begin
        dec_cls = C_NONE;
        case (opcode)
            7'b0110111: dec_cls = C_LUI;
            7'b0010111: dec_cls = C_AUIPC;
            7'b1101111: dec_cls = C_JAL;
            7'b1100111: dec_cls = C_JALR;
            7'b1100011: dec_cls = (funct3 == 3'd2 || funct3 == 3'd3)
                                  ? C_NONE : C_BRANCH;
            7'b0000011: dec_cls = C_LOAD;
            7'b0100011: dec_cls = C_STORE;
            7'b0010011: dec_cls = C_OPIMM;
            7'b0110011: dec_cls = C_OP;
            default:    dec_cls = C_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            cls        <= C_NONE;
            cnt        <= '0;
            taken      <= 1'b0;
            instret    <= '0;
            trap_cause <= 2'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        state <= DECODE;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state      <= TRAP;
                        trap_cause <= 2'd2;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DECODE: begin
                    cnt <= '0;
                    if (dec_cls == C_NONE) begin
                        state      <= TRAP;
                        trap_cause <= 2'd1;
                    end else begin
                        cls   <= dec_cls;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    taken <= branch_taken;
                    state <= (cls == C_LOAD || cls == C_STORE) ? MEM : WB;
                end
                MEM: begin
                    if (dmem_ready) begin
                        cnt <= '0;
                        if (cls == C_STORE) begin
                            instret <= instret + 32'd1;
                            state   <= FETCH;
                        end else begin
                            state <= WB;
                        end
                    end else if (cnt == CNT_MAX) begin
                        state      <= TRAP;
                        trap_cause <= 2'd3;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WB: begin
                    instret <= instret + 32'd1;
                    state   <= FETCH;
                end
                TRAP:    state <= TRAP;
                default: state <= TRAP;
            endcase
        end
    end

    assign halted = (state == TRAP);

    // Strobes are a pure function of state/class so a reset edge
    // abandons whatever was in flight without a late write.
    always_comb begin
        imem_req    = 1'b0;
        ir_we       = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        rf_we       = 1'b0;
        alu_src_imm = 1'b0;
        wb_sel      = 2'd0;
        pc_we       = 1'b0;
        pc_sel      = 2'd0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                EXEC: alu_src_imm = !(cls == C_OP || cls == C_BRANCH);
                MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (cls == C_STORE);
                    pc_we    = (cls == C_STORE) && dmem_ready;
                end
                WB: begin
                    rf_we = (cls != C_BRANCH);
                    pc_we = 1'b1;
                    case (cls)
                        C_JAL:    pc_sel = 2'd1;
                        C_JALR:   pc_sel = 2'd2;
                        C_BRANCH: pc_sel = taken ? 2'd1 : 2'd0;
                        default:  pc_sel = 2'd0;
                    endcase
                    case (cls)
                        C_LOAD:         wb_sel = 2'd1;
                        C_JAL, C_JALR:  wb_sel = 2'd2;
                        C_LUI:          wb_sel = 2'd3;
                        default:        wb_sel = 2'd0;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
